// File: rtl/pd_tcpc_pkg.sv
// Shared definitions for the USB-PD TCPC hard/cable reset blocks.
// Holds the reset-handling FSM encoding, ALERT and RECEIVE_DETECT bit
// positions, received frame-type codes and the timeout counter width.
package pd_tcpc_pkg;

  typedef enum logic [5:0] {
    ST_IDLE           = 6'b000001,
    ST_WAIT_FOR_RESET = 6'b000010,
    ST_RESET_LAYER    = 6'b000100,
    ST_INDICATE       = 6'b001000,
    ST_WAIT_COMPLETE  = 6'b010000,
    ST_REPORT         = 6'b100000
  } hr_state_t;

  localparam int ALERT_RX_HARD_RESET = 3;
  localparam int RD_EN_HARD_RESET    = 5;
  localparam int RD_EN_CABLE_RESET   = 6;

  localparam logic [2:0] FRAME_NONE        = 3'b000;
  localparam logic [2:0] FRAME_HARD_RESET  = 3'b101;
  localparam logic [2:0] FRAME_CABLE_RESET = 3'b110;

  localparam int HR_CNT_W = 10;

  // Hard Reset takes precedence when both ordered sets qualify together.
  function automatic logic [2:0] reset_frame_type(input logic hard);
    return hard ? FRAME_HARD_RESET : FRAME_CABLE_RESET;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Free-running cycle counter used to time out TCPM reset handling.
// Ports: CLK clock, reset sync active-high, clear (priority over enable),
// enable increments by one per cycle, count current value.
module cycle_counter
  import pd_tcpc_pkg::*;
(
  input  logic                CLK,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  output logic [HR_CNT_W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + HR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/hard_reset_receiver.sv
// Receive-side Hard/Cable Reset handler of the TCPC.
// Ports: CLK, reset (sync active-high); PHY_HR_RX / PHY_CR_RX ordered-set
// pulses from the PHY; RECEIVE_DETECT_WR + iRECEIVE_DETECT register write;
// ALERT_CLEAR write-1-to-clear mask; PE_HR_DONE completion from the TCPM.
// Outputs (all registered): oRECEIVE_DETECT, ALERT, oRX_FRAME_TYPE,
// PRL_Reset one-cycle protocol-layer reset, HR_Busy, sticky HR_Timeout.
module hard_reset_receiver
  import pd_tcpc_pkg::*;
#(
  parameter int HR_COMPLETE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        PHY_HR_RX,
  input  logic        PHY_CR_RX,
  input  logic        RECEIVE_DETECT_WR,
  input  logic [7:0]  iRECEIVE_DETECT,
  input  logic [15:0] ALERT_CLEAR,
  input  logic        PE_HR_DONE,
  output logic [7:0]  oRECEIVE_DETECT,
  output logic [15:0] ALERT,
  output logic [2:0]  oRX_FRAME_TYPE,
  output logic        PRL_Reset,
  output logic        HR_Busy,
  output logic        HR_Timeout
);

  localparam logic [HR_CNT_W-1:0] TERM_COUNT = HR_CNT_W'(HR_COMPLETE_CYCLES - 1);

  hr_state_t           state;
  logic [HR_CNT_W-1:0] count;
  logic                det_hard;
  logic                det_cable;
  logic                detect;
  logic                term;

  // Only enabled ordered sets count, and only while listening.
  assign det_hard  = PHY_HR_RX & oRECEIVE_DETECT[RD_EN_HARD_RESET];
  assign det_cable = PHY_CR_RX & oRECEIVE_DETECT[RD_EN_CABLE_RESET];
  assign detect    = (state == ST_WAIT_FOR_RESET) & (det_hard | det_cable);
  assign term      = (count == TERM_COUNT);

  // Counter is zeroed on the way out of INDICATE and runs only while waiting.
  cycle_counter u_cycle_counter (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (state == ST_INDICATE),
    .enable (state == ST_WAIT_COMPLETE),
    .count  (count)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state           <= ST_IDLE;
      ALERT           <= '0;
      oRECEIVE_DETECT <= '0;
      oRX_FRAME_TYPE  <= FRAME_NONE;
      PRL_Reset       <= 1'b0;
      HR_Busy         <= 1'b0;
      HR_Timeout      <= 1'b0;
    end else begin
      PRL_Reset <= 1'b0;
      // Later per-bit assignments below override the clear (set wins).
      ALERT <= ALERT & ~ALERT_CLEAR;
      if (RECEIVE_DETECT_WR) begin
        oRECEIVE_DETECT <= iRECEIVE_DETECT;
      end

      case (state)
        ST_IDLE: begin
          state <= ST_WAIT_FOR_RESET;
        end
        ST_WAIT_FOR_RESET: begin
          if (detect) begin
            state           <= ST_RESET_LAYER;
            PRL_Reset       <= 1'b1;
            HR_Busy         <= 1'b1;
            HR_Timeout      <= 1'b0;
            oRECEIVE_DETECT <= '0;
            oRX_FRAME_TYPE  <= reset_frame_type(det_hard);
          end
        end
        ST_RESET_LAYER: begin
          state <= ST_INDICATE;
        end
        ST_INDICATE: begin
          state                      <= ST_WAIT_COMPLETE;
          ALERT[ALERT_RX_HARD_RESET] <= 1'b1;
        end
        ST_WAIT_COMPLETE: begin
          // Completion beats the terminal count when both arrive together.
          if (PE_HR_DONE) begin
            state <= ST_REPORT;
          end else if (term) begin
            state      <= ST_REPORT;
            HR_Timeout <= 1'b1;
          end
        end
        ST_REPORT: begin
          state   <= ST_WAIT_FOR_RESET;
          HR_Busy <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hard_reset_receiver.sv
module tb_hard_reset_receiver;

  localparam int HRC = 16;

  logic        CLK;
  logic        reset;
  logic        PHY_HR_RX;
  logic        PHY_CR_RX;
  logic        RECEIVE_DETECT_WR;
  logic [7:0]  iRECEIVE_DETECT;
  logic [15:0] ALERT_CLEAR;
  logic        PE_HR_DONE;
  logic [7:0]  oRECEIVE_DETECT;
  logic [15:0] ALERT;
  logic [2:0]  oRX_FRAME_TYPE;
  logic        PRL_Reset;
  logic        HR_Busy;
  logic        HR_Timeout;

  hard_reset_receiver #(.HR_COMPLETE_CYCLES(HRC)) dut (
    .CLK               (CLK),
    .reset             (reset),
    .PHY_HR_RX         (PHY_HR_RX),
    .PHY_CR_RX         (PHY_CR_RX),
    .RECEIVE_DETECT_WR (RECEIVE_DETECT_WR),
    .iRECEIVE_DETECT   (iRECEIVE_DETECT),
    .ALERT_CLEAR       (ALERT_CLEAR),
    .PE_HR_DONE        (PE_HR_DONE),
    .oRECEIVE_DETECT   (oRECEIVE_DETECT),
    .ALERT             (ALERT),
    .oRX_FRAME_TYPE    (oRX_FRAME_TYPE),
    .PRL_Reset         (PRL_Reset),
    .HR_Busy           (HR_Busy),
    .HR_Timeout        (HR_Timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_bad = 0;
  int prl_seen = 0;

  // Reference model: tracks elapsed edges since a detection instead of FSM states.
  bit          m_ready, m_busy, m_report, m_prl, m_to;
  int          m_age;
  logic [7:0]  m_rd;
  logic [15:0] m_alert;
  logic [2:0]  m_ft;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic hard, det;
    logic [15:0] a;
    if (reset) begin
      m_ready = 0; m_busy = 0; m_report = 0; m_age = 0; m_prl = 0; m_to = 0;
      m_rd = '0; m_alert = '0; m_ft = '0;
      return;
    end
    hard = PHY_HR_RX && m_rd[5];
    det  = m_ready && !m_busy && (hard || (PHY_CR_RX && m_rd[6]));
    a = m_alert & ~ALERT_CLEAR;
    m_prl = 0;
    if (RECEIVE_DETECT_WR) m_rd = iRECEIVE_DETECT;
    if (!m_ready) begin
      m_ready = 1;
    end else if (det) begin
      m_busy = 1; m_report = 0; m_age = 0; m_to = 0; m_prl = 1;
      m_rd = '0;
      m_ft = hard ? 3'b101 : 3'b110;
    end else if (m_busy) begin
      if (m_report) begin
        m_busy = 0; m_report = 0;
      end else begin
        m_age++;
        if (m_age == 2) begin
          a[3] = 1'b1;
        end else if (m_age >= 3) begin
          if (PE_HR_DONE) m_report = 1;
          else if (m_age == HRC + 2) begin
            m_report = 1; m_to = 1;
          end
        end
      end
    end
    m_alert = a;
  endtask

  task automatic cyc(input logic hr, input logic cr, input logic wr, input logic [7:0] wd,
                     input logic [15:0] clr, input logic done, input logic rst);
    PHY_HR_RX = hr; PHY_CR_RX = cr; RECEIVE_DETECT_WR = wr; iRECEIVE_DETECT = wd;
    ALERT_CLEAR = clr; PE_HR_DONE = done; reset = rst;
    @(posedge CLK);
    model_step();
    #1;
    if (PRL_Reset === 1'b1) prl_seen++;
    chk("rd",    16'(oRECEIVE_DETECT), 16'(m_rd));
    chk("alert", ALERT,                m_alert);
    chk("ftype", 16'(oRX_FRAME_TYPE),  16'(m_ft));
    chk("prl",   16'(PRL_Reset),       16'(m_prl));
    chk("busy",  16'(HR_Busy),         16'(m_busy));
    chk("tmo",   16'(HR_Timeout),      16'(m_to));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 8'h00, 16'h0, 0, 0);
  endtask

  task automatic wr_rd(input logic [7:0] v);
    cyc(0, 0, 1, v, 16'h0, 0, 0);
  endtask

  int done_div;

  initial begin
    m_ready = 0; m_busy = 0; m_report = 0; m_age = 0; m_prl = 0; m_to = 0;
    m_rd = '0; m_alert = '0; m_ft = '0;
    PHY_HR_RX = 0; PHY_CR_RX = 0; RECEIVE_DETECT_WR = 0; iRECEIVE_DETECT = 0;
    ALERT_CLEAR = 0; PE_HR_DONE = 0; reset = 1;

    // reset state
    cyc(0, 0, 0, 8'h00, 16'h0, 0, 1);
    cyc(0, 0, 0, 8'h00, 16'h0, 0, 1);
    chk("rst_alert", ALERT, 16'h0);
    chk("rst_busy", 16'(HR_Busy), 16'h0);
    idle();

    // hard reset, completion three cycles into the wait
    wr_rd(8'h20);
    prl_seen = 0;
    cyc(1, 0, 0, 8'h00, 16'h0, 0, 0);
    chk("hr_prl", 16'(PRL_Reset), 16'h1);
    chk("hr_ft", 16'(oRX_FRAME_TYPE), 16'h5);
    chk("hr_rd0", 16'(oRECEIVE_DETECT), 16'h0);
    idle();
    chk("hr_prl_off", 16'(PRL_Reset), 16'h0);
    idle();
    chk("hr_alert", ALERT, 16'h0008);
    idle(); idle();
    cyc(0, 0, 0, 8'h00, 16'h0, 1, 0);
    idle();
    chk("hr_busy_off", 16'(HR_Busy), 16'h0);
    chk("hr_tmo0", 16'(HR_Timeout), 16'h0);
    chk("hr_one_prl", 16'(prl_seen), 16'h1);
    cyc(0, 0, 0, 8'h00, 16'hffff, 0, 0);

    // cable reset with only the hard enable set is ignored
    wr_rd(8'h20);
    prl_seen = 0;
    cyc(0, 1, 0, 8'h00, 16'h0, 0, 0);
    idle(); idle(); idle();
    chk("cr_ign_busy", 16'(HR_Busy), 16'h0);
    chk("cr_ign_alert", ALERT, 16'h0);
    chk("cr_ign_prl", 16'(prl_seen), 16'h0);

    // both at once resolves to hard
    wr_rd(8'h60);
    cyc(1, 1, 0, 8'h00, 16'h0, 0, 0);
    chk("both_ft", 16'(oRX_FRAME_TYPE), 16'h5);
    idle(); idle(); idle();
    cyc(0, 0, 0, 8'h00, 16'h0, 1, 0);
    idle();
    cyc(0, 0, 0, 8'h00, 16'h0008, 0, 0);

    // timeout with no completion
    wr_rd(8'h20);
    cyc(1, 0, 0, 8'h00, 16'h0, 0, 0);
    for (int j = 1; j <= 20; j++) begin
      idle();
      chk("to_time", 16'(HR_Timeout), (j >= 18) ? 16'h1 : 16'h0);
      chk("to_busy", 16'(HR_Busy), (j >= 19) ? 16'h0 : 16'h1);
    end
    cyc(0, 0, 0, 8'h00, 16'h0008, 0, 0);
    chk("to_alert_clr", ALERT, 16'h0);

    // completion on the terminal-count edge is a success
    wr_rd(8'h40);
    cyc(0, 1, 0, 8'h00, 16'h0, 0, 0);
    chk("cr_ft", 16'(oRX_FRAME_TYPE), 16'h6);
    for (int j = 1; j <= 17; j++) idle();
    cyc(0, 0, 0, 8'h00, 16'h0, 1, 0);
    chk("tie_tmo", 16'(HR_Timeout), 16'h0);
    idle();
    chk("tie_busy", 16'(HR_Busy), 16'h0);

    // second hard reset during the wait is ignored
    wr_rd(8'h20);
    prl_seen = 0;
    cyc(1, 0, 0, 8'h00, 16'h0, 0, 0);
    idle(); idle(); idle(); idle();
    cyc(1, 0, 1, 8'h20, 16'h0, 0, 0);
    idle(); idle();
    cyc(0, 0, 0, 8'h00, 16'h0, 1, 0);
    idle();
    chk("dbl_one_prl", 16'(prl_seen), 16'h1);

    // reset in the middle of the wait, then a fresh detection
    wr_rd(8'h20);
    cyc(1, 0, 0, 8'h00, 16'h0, 0, 0);
    idle(); idle(); idle();
    cyc(0, 0, 0, 8'h00, 16'h0, 0, 1);
    chk("mid_rst_alert", ALERT, 16'h0);
    chk("mid_rst_busy", 16'(HR_Busy), 16'h0);
    chk("mid_rst_ft", 16'(oRX_FRAME_TYPE), 16'h0);
    idle();
    wr_rd(8'h20);
    cyc(1, 0, 0, 8'h00, 16'h0, 0, 0);
    chk("post_rst_prl", 16'(PRL_Reset), 16'h1);
    idle(); idle(); idle();
    cyc(0, 0, 0, 8'h00, 16'h0, 1, 0);
    idle();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] wd;
      done_div = ((i / 500) % 2 == 0) ? 4 : 40;
      wd = 8'($urandom);
      if ($urandom_range(0, 1) == 0) wd = wd | 8'h20;
      if ($urandom_range(0, 1) == 0) wd = wd | 8'h40;
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 7) == 0, wd,
          ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0,
          $urandom_range(0, done_div - 1) == 0,
          $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/hard_reset_receiver.md
HARD_RESET_RECEIVER -- requirements
Module: hard_reset_receiver

Interface
REQ-001 SHALL have parameter HR_COMPLETE_CYCLES, default 16, meaning cycles allowed for the TCPM to complete Hard/Cable Reset handling (legal range 2..1023).
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PHY_HR_RX  input  1  one-cycle pulse: PHY received a Hard Reset ordered set.
REQ-005 SHALL have port PHY_CR_RX  input  1  one-cycle pulse: PHY received a Cable Reset ordered set.
REQ-006 SHALL have port RECEIVE_DETECT_WR  input  1  TCPM write strobe for RECEIVE_DETECT.
REQ-007 SHALL have port iRECEIVE_DETECT  input  8  RECEIVE_DETECT write data.
REQ-008 SHALL have port ALERT_CLEAR  input  16  write-1-to-clear mask for ALERT, valid one cycle.
REQ-009 SHALL have port PE_HR_DONE  input  1  TCPM indicates reset handling complete.
REQ-010 SHALL have port oRECEIVE_DETECT  output  8  RECEIVE_DETECT register; bit5 EnableHardReset, bit6 EnableCableReset.
REQ-011 SHALL have port ALERT  output  16  alert register; bit3 ReceivedHardReset.
REQ-012 SHALL have port oRX_FRAME_TYPE  output  3  received reset type: 3'b101 Hard, 3'b110 Cable.
REQ-013 SHALL have port PRL_Reset  output  1  one-cycle pulse resetting the protocol layer (aborts transmit).
REQ-014 SHALL have port HR_Busy  output  1  high while a received reset is being processed.
REQ-015 SHALL have port HR_Timeout  output  1  sticky: last reset handling timed out.

Function
REQ-016 All outputs SHALL be registered; one-hot states IDLE, WAIT_FOR_RESET, RESET_LAYER, INDICATE, WAIT_COMPLETE, REPORT.
REQ-017 IDLE SHALL go to WAIT_FOR_RESET unconditionally on the first edge after reset deasserts.
REQ-018 In WAIT_FOR_RESET, a detection is (PHY_HR_RX & oRECEIVE_DETECT[5]) | (PHY_CR_RX & oRECEIVE_DETECT[6]); pulses whose enable bit is 0 SHALL be ignored.
REQ-019 On a detection sampled at edge k, after edge k: state RESET_LAYER, PRL_Reset=1, HR_Busy=1, HR_Timeout=0, oRECEIVE_DETECT=8'h00, oRX_FRAME_TYPE=101 (Hard) or 110 (Cable).
REQ-020 Hard and Cable Reset detected in the same cycle SHALL be treated as Hard Reset.
REQ-021 RESET_LAYER SHALL go to INDICATE after one cycle; PRL_Reset SHALL be 0 after edge k+1 (exactly one cycle wide).
REQ-022 Leaving INDICATE SHALL set ALERT[3] (visible after edge k+2) and clear the cycle counter to 0.
REQ-023 In WAIT_COMPLETE the counter SHALL increment every cycle; PE_HR_DONE=1 -> REPORT (success); else counter == HR_COMPLETE_CYCLES-1 -> REPORT with HR_Timeout set.
REQ-024 PE_HR_DONE and the terminal count in the same cycle SHALL be success.
REQ-025 REPORT SHALL go to WAIT_FOR_RESET after one cycle and drop HR_Busy on that edge.
REQ-026 PHY_HR_RX/PHY_CR_RX in any state other than WAIT_FOR_RESET SHALL be ignored (no re-entry, no counter restart).
REQ-027 RECEIVE_DETECT_WR SHALL load iRECEIVE_DETECT in any state, except on a detection edge, where the clear wins.
REQ-028 ALERT bits SHALL clear where ALERT_CLEAR=1; a same-cycle set of ALERT[3] SHALL win over its clear; other ALERT bits are held.
REQ-029 PE_HR_DONE outside WAIT_COMPLETE SHALL be ignored.

Reset
REQ-030 reset=1 at any edge, mid-operation included, SHALL force IDLE, counter=0, ALERT=0, oRECEIVE_DETECT=0, oRX_FRAME_TYPE=0, PRL_Reset=0, HR_Busy=0, HR_Timeout=0.

Structure
REQ-031 State encodings, ALERT bit positions, RECEIVE_DETECT bit positions and frame-type codes SHALL live in the shared package pd_tcpc_pkg, used by both hard-reset transmit and receive blocks.
REQ-032 The timeout counter SHALL be one sub-module, cycle_counter (clear, enable, 10-bit count output); everything else stays in hard_reset_receiver.

Verification
REQ-033 RECEIVE_DETECT written 8'h20, PHY_HR_RX pulse -> PRL_Reset one cycle, oRX_FRAME_TYPE=101, oRECEIVE_DETECT=0, ALERT=16'h0008 two edges later; PE_HR_DONE 3 cycles later -> HR_Busy low, HR_Timeout=0.
REQ-034 RECEIVE_DETECT=8'h20, PHY_CR_RX pulse -> no state change, ALERT=0, PRL_Reset never high.
REQ-035 RECEIVE_DETECT=8'h60, PHY_HR_RX and PHY_CR_RX same cycle -> oRX_FRAME_TYPE=101.
REQ-036 HR_COMPLETE_CYCLES=16, no PE_HR_DONE -> HR_Timeout=1 16 cycles after entering WAIT_COMPLETE, back to WAIT_FOR_RESET; ALERT_CLEAR=16'h0008 -> ALERT=0.
REQ-037 Second PHY_HR_RX during WAIT_COMPLETE -> ignored, single PRL_Reset pulse total.
REQ-038 reset asserted in WAIT_COMPLETE -> all outputs 0 next edge; new detection after re-enable processed normally.
